// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> hazard scoreboard bundle: instruction operands in, stall/forward selects out.
// HAZARD_SCOREBOARD_STATS_EN adds the stall_count return signal.
interface hazard_scoreboard_if #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LAT_W  = 2
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic              hold;
    logic              id_valid;
    logic              id_flush;
    logic [ADDR_W-1:0] id_rs_addr;
    logic              id_rs_used;
    logic [ADDR_W-1:0] id_rt_addr;
    logic              id_rt_used;
    logic              id_we;
    logic [ADDR_W-1:0] id_wr_addr;
    logic [LAT_W-1:0]  id_lat;
    logic              stall;
    logic [SEL_W-1:0]  rs_fwd_sel;
    logic [SEL_W-1:0]  rt_fwd_sel;
    logic              busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0]       stall_count;
`endif

    modport master (
        output hold, id_valid, id_flush, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
        output id_we, id_wr_addr, id_lat,
        input  stall, rs_fwd_sel, rt_fwd_sel, busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
        , input stall_count
`endif
    );

    modport slave (
        input  hold, id_valid, id_flush, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
        input  id_we, id_wr_addr, id_lat,
        output stall, rs_fwd_sel, rt_fwd_sel, busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
        , output stall_count
`endif
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard tracker: shift record of in-flight writes with producer latency.
// Define HAZARD_SCOREBOARD_STATS_EN to add the saturating stall_count output.
module hazard_scoreboard #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LAT_W  = 2
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic [DEPTH:1]    v_q, v_d;
    logic [ADDR_W-1:0] addr_q [1:DEPTH];
    logic [ADDR_W-1:0] addr_d [1:DEPTH];
    logic [LAT_W-1:0]  lat_q  [1:DEPTH];
    logic [LAT_W-1:0]  lat_d  [1:DEPTH];

    logic             rs_haz, rt_haz, stall, issue;
    logic [SEL_W-1:0] rs_sel, rt_sel;

    // Returns {hazard, sel} for one source operand.
    function automatic logic [SEL_W:0] lookup(input logic [ADDR_W-1:0] addr, input logic used);
        logic [SEL_W:0] res;
        res = '0;
        if (used && addr != '0) begin
            // Oldest to youngest so the youngest producer overrides any older WAW match.
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (v_q[k] && addr_q[k] == addr) begin
                    if (k >= int'(lat_q[k])) res = {1'b0, SEL_W'(k)};
                    else                     res = {1'b1, {SEL_W{1'b0}}};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {rs_haz, rs_sel} = lookup(sb.id_rs_addr, sb.id_rs_used);
        {rt_haz, rt_sel} = lookup(sb.id_rt_addr, sb.id_rt_used);
        stall = sb.id_valid & ~sb.id_flush & (rs_haz | rt_haz);
        issue = sb.id_valid & ~sb.id_flush & ~stall & ~sb.hold;

        v_d       = '0;
        v_d[1]    = issue & sb.id_we & (sb.id_wr_addr != '0);
        addr_d[1] = sb.id_wr_addr;
        lat_d[1]  = (sb.id_lat == '0) ? LAT_W'(1) : sb.id_lat;
        for (int k = 2; k <= int'(DEPTH); k++) begin
            v_d[k]    = v_q[k-1];
            addr_d[k] = addr_q[k-1];
            lat_d[k]  = lat_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           v_q <= '0;
        else if (!sb.hold) v_q <= v_d;
    end

    // Payload needs no reset; it is only observed through v_q.
    always_ff @(posedge clk) begin
        if (!sb.hold) begin
            addr_q <= addr_d;
            lat_q  <= lat_d;
        end
    end

    assign sb.stall      = stall;
    assign sb.rs_fwd_sel = rs_sel;
    assign sb.rt_fwd_sel = rt_sel;
    assign sb.busy       = |v_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !sb.hold && stall_count_q != 32'hFFFF_FFFF) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_count_q <= '0;
        else     stall_count_q <= stall_count_d;
    end

    assign sb.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard (DEPTH=3): driver queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_scoreboard;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned LAT_W  = 2;

    typedef struct {
        string name;
        logic  hold;
        logic  rst;
        logic  stall;
        int    rs_sel;
        int    rt_sel;
        logic  busy;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    hazard_scoreboard_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT_W(LAT_W)) sb_if ();

    hazard_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one decode cycle and queue what the outputs must show during it.
    task automatic cyc(input string nm, input logic hd, input logic r,
                       input logic v, input logic fl,
                       input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                       input logic we, input logic [4:0] wa, input logic [1:0] lat,
                       input logic e_stall, input int e_rs, input int e_rt, input logic e_busy);
        exp_t e;
        sb_if.hold       = hd;
        rst              = r;
        sb_if.id_valid   = v;
        sb_if.id_flush   = fl;
        sb_if.id_rs_addr = rs;
        sb_if.id_rs_used = rsu;
        sb_if.id_rt_addr = rt;
        sb_if.id_rt_used = rtu;
        sb_if.id_we      = we;
        sb_if.id_wr_addr = wa;
        sb_if.id_lat     = lat;
        e.name   = nm;
        e.hold   = hd;
        e.rst    = r;
        e.stall  = e_stall;
        e.rs_sel = e_rs;
        e.rt_sel = e_rt;
        e.busy   = e_busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares once per cycle, away from the active edge.
    initial begin : monitor
        exp_t e;
        logic [31:0] cnt_model;
        cnt_model = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".stall"}, int'(sb_if.stall), int'(e.stall));
                chk({e.name, ".rs_sel"}, int'(sb_if.rs_fwd_sel), e.rs_sel);
                chk({e.name, ".rt_sel"}, int'(sb_if.rt_fwd_sel), e.rt_sel);
                chk({e.name, ".busy"}, int'(sb_if.busy), int'(e.busy));
`ifdef HAZARD_SCOREBOARD_STATS_EN
                chk({e.name, ".stall_count"}, int'(sb_if.stall_count), int'(cnt_model));
`endif
                if (e.rst) cnt_model = '0;
                else if (e.stall && !e.hold && cnt_model != 32'hFFFF_FFFF) cnt_model++;
            end
        end
    end

    initial begin : driver
        n_chk  = 0;
        n_fail = 0;
        rst              = 1'b1;
        sb_if.hold       = 1'b0;
        sb_if.id_valid   = 1'b0;
        sb_if.id_flush   = 1'b0;
        sb_if.id_rs_addr = '0;
        sb_if.id_rs_used = 1'b0;
        sb_if.id_rt_addr = '0;
        sb_if.id_rt_used = 1'b0;
        sb_if.id_we      = 1'b0;
        sb_if.id_wr_addr = '0;
        sb_if.id_lat     = '0;
        repeat (2) @(posedge clk);
        #1;
        //  name         hd r  v fl rs ru rt tu we wa lat  stall rs rt busy
        cyc("reset",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // ALU chain
        cyc("alu_issue",  0, 0, 1, 0, 0, 0, 0, 0, 1, 8, 1,  0, 0, 0, 0);
        cyc("alu_rs",     0, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0,  0, 1, 0, 1);
        cyc("alu_rt",     0, 0, 1, 0, 0, 0, 8, 1, 0, 0, 0,  0, 0, 2, 1);
        cyc("alu_drain",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // Load-use
        cyc("ld_issue",   0, 0, 1, 0, 0, 0, 0, 0, 1, 9, 2,  0, 0, 0, 0);
        cyc("ld_use1",    0, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0,  1, 0, 0, 1);
        cyc("ld_use2",    0, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0,  0, 0, 2, 1);
        // Mul latency 3
        cyc("mul_issue",  0, 0, 1, 0, 0, 0, 0, 0, 1, 10, 3, 0, 0, 0, 1);
        cyc("mul_use1",   0, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("mul_use2",   0, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("mul_use3",   0, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1);
        cyc("mul_gone",   0, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // WAW: youngest (addu, lat 1) wins over older load
        cyc("waw_lw",     0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 2,  0, 0, 0, 0);
        cyc("waw_addu",   0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 1,  0, 0, 0, 1);
        cyc("waw_rd",     0, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0,  0, 1, 0, 1);
        cyc("waw_d1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        cyc("waw_d2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // Writes to $0 never recorded; lat 0 treated as 1
        cyc("zero_wr",    0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
        cyc("zero_chk",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // Flush suppresses stall and issue
        cyc("fl_lw",      0, 0, 1, 0, 0, 0, 0, 0, 1, 9, 2,  0, 0, 0, 0);
        cyc("fl_dep",     0, 0, 1, 1, 9, 1, 0, 0, 1, 12, 1, 0, 0, 0, 1);
        cyc("fl_chk",     0, 0, 1, 0, 9, 1, 12, 1, 0, 0, 0, 0, 2, 0, 1);
        cyc("fl_drain",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // Hold freezes the load in stage 1
        cyc("hd_lw",      0, 0, 1, 0, 0, 0, 0, 0, 1, 7, 2,  0, 0, 0, 0);
        cyc("hd_1",       1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);
        cyc("hd_2",       1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);
        cyc("hd_3",       1, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);
        cyc("hd_rel",     0, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);
        cyc("hd_fwd",     0, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0,  0, 2, 0, 1);
        // Reset mid-flight, with priority over hold
        cyc("rst_lw",     0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 2,  0, 0, 0, 1);
        cyc("rst_mid",    1, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);
        cyc("rst_chk",    0, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised pipeline hazard tracker for the MIPS decode stage; replaces the fixed single-path (rs-only, MEM-only) forwarding/stall logic.
- Holds a shift-register record of in-flight register writes across DEPTH downstream stages, each tagged with its producer latency (ALU, load, mul).
- Outputs per-operand forward selects for rs and rt, and a decode stall when the youngest matching producer is not yet ready.

Parameters:
DEPTH, 3, number of tracked downstream stages (1=EX, 2=MEM, ..., DEPTH=last stage before regfile commit)
ADDR_W, 5, register address width
LAT_W, 2, width of producer latency field

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
hold  input  1  global pipeline freeze (memory wait); scoreboard contents frozen
id_valid  input  1  decode holds a real instruction
id_flush  input  1  decode instruction is squashed (taken branch/jump shadow)
id_rs_addr  input  ADDR_W  rs source address
id_rs_used  input  1  instruction reads rs
id_rt_addr  input  ADDR_W  rt source address
id_rt_used  input  1  instruction reads rt
id_we  input  1  instruction writes a register
id_wr_addr  input  ADDR_W  destination register
id_lat  input  LAT_W  stage index at which the result becomes forwardable (1=EX ALU, 2=load, 3=mul); 0 is treated as 1
stall  output  1  hold decode/fetch, insert bubble
rs_fwd_sel  output  SEL_W  0=regfile, k=forward from stage k; SEL_W=$clog2(DEPTH+1)
rt_fwd_sel  output  SEL_W  same for rt
busy  output  1  any valid entry in flight

Behaviour:
- Entry per stage k in 1..DEPTH: {v, addr, lat}. Reset clears all v; stall=0, fwd_sel=0, busy=0 combinationally follow.
- issue = id_valid & ~id_flush & ~stall & ~hold.
- Each rising clk with ~hold: stage k+1 <= stage k for k<DEPTH; stage 1 <= issue & id_we & (id_wr_addr!=0) ? {1, id_wr_addr, max(id_lat,1)} : bubble (v=0). Entry leaving stage DEPTH is committed to the regfile and dropped.
- hold=1: all entries unchanged; outputs still computed from current contents.
- rst has priority over hold; rst mid-operation discards all entries.
- Per operand (rs shown; rt identical), combinational:
  - If addr==0 or ~used: sel=0, no hazard.
  - Otherwise find the smallest k with v_k & addr_k==addr (youngest producer). If none: sel=0.
  - If k >= lat_k: sel=k. Else: hazard, and sel is don't-care (driven 0).
- stall = id_valid & ~id_flush & (rs_hazard | rt_hazard). id_flush suppresses stall.
- Stall inserts a bubble into stage 1 while older entries advance, so a load in EX (lat 2) gives exactly 1 stall cycle and a mul (lat 3) up to 2.
- Older matching entries are ignored when a younger match exists (WAW correctness).
- DEPTH commit: the regfile is written at end of stage DEPTH, and the regfile is write-through to decode, so no entry survives beyond DEPTH.
- busy = OR of all v.
- No registered outputs; latency from input change to stall/sel is 0 cycles; scoreboard update latency is 1 cycle.

Optional Feature:
- HAZARD_SCOREBOARD_STATS_EN defined: adds output stall_count [31:0].
- stall_count increments on each clk where stall & ~hold & ~rst, saturates at 32'hFFFF_FFFF, and is cleared by rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- ALU chain, no stall: issue addu $8 (lat1); next cycle decode reads rs=$8 -> stall=0, rs_fwd_sel=1; following cycle rt=$8 -> rt_fwd_sel=2.
- Load-use: issue lw $9 (lat2); next decode uses rt=$9 -> stall=1 for exactly 1 cycle, then rt_fwd_sel=2; stall_count=1 with feature enabled.
- Mul latency with DEPTH=3: issue mul $10 (lat3); dependent rs=$10 -> stall for 2 cycles, then rs_fwd_sel=3; after one more advance with no match, rs_fwd_sel=0.
- WAW/zero/flush: issue lw $5 then addu $5; reader of $5 -> rs_fwd_sel=1, stall=0. Write to $0 never recorded (busy stays 0). A dependent instruction with id_flush=1 -> stall=0 and no entry issued.
- Hold and reset: with a load in stage 1, hold=1 for 3 cycles -> entry stays in stage 1 and stall stays 1; release -> advances. Assert rst mid-flight -> next cycle busy=0, stall=0, sels=0.
